// File: rtl/formation_pkg.sv
// ---------------------------------------------------------------------------
// formation_pkg
//   Shared definitions for the enemy-formation controller:
//   - state_t      : controller FSM states
//   - MAX_IDX_W    : index width of the widest grid mask the helpers accept
//   - MAX_CELLS    : number of cells that MAX_IDX_W can address
//   - col_any()    : OR of every row's bit in one column of a row-major mask
// ---------------------------------------------------------------------------
package formation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SCAN,
    ST_STEP,
    ST_HALT
  } state_t;

  localparam int MAX_IDX_W = 10;
  localparam int MAX_CELLS = 1 << MAX_IDX_W;
  localparam int MAX_ROWS  = 32;

  // The mask is zero-extended to MAX_CELLS bits by the caller, so one
  // function body serves every ROWS x COLS grid up to that size. Cell
  // (r, c) lives at bit r*cols + c.
  function automatic logic col_any(input logic [MAX_CELLS-1:0] mask,
                                   input int rows,
                                   input int cols,
                                   input int col);
    logic                 hit;
    logic [MAX_IDX_W-1:0] bit_idx;
    hit     = 1'b0;
    bit_idx = '0;
    for (int r = 0; r < MAX_ROWS; r++) begin
      if (r < rows) begin
        bit_idx = MAX_IDX_W'(r * cols + col);
        hit     = hit | mask[bit_idx];
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/formation_scan.sv
// ---------------------------------------------------------------------------
// formation_scan
//   Sequential column scanner. Visits one column per cycle, starting at
//   column 0 in the cycle where start is high, and records the lowest and
//   highest column that still holds a live enemy.
//
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     start       : high for the first scan cycle (column 0 is visited then)
//     snapshot    : alive mask to scan, must stay stable during the scan
//     min_col     : lowest column with any live enemy
//     max_col     : highest column with any live enemy
//     any         : at least one live enemy was found
//     done        : high in the cycle that visits the last column; the
//                   results are valid from the following cycle on
// ---------------------------------------------------------------------------
module formation_scan #(
  parameter int ROWS = 5,
  parameter int COLS = 11,
  parameter int CW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] snapshot,
  output logic [CW-1:0]        min_col,
  output logic [CW-1:0]        max_col,
  output logic                 any,
  output logic                 done
);
  import formation_pkg::*;

  logic                 busy;
  logic [CW-1:0]        col;
  logic [CW-1:0]        cur_col;
  logic                 active;
  logic                 cur_hit;
  logic [MAX_CELLS-1:0] snap_ext;

  // A start restarts the scan at column 0 even if an older scan is still
  // running, so a formation reload never has to flush the scanner.
  assign snap_ext = MAX_CELLS'(snapshot);
  assign cur_col  = start ? '0 : col;
  assign active   = start | busy;
  assign cur_hit  = col_any(snap_ext, ROWS, COLS, int'(cur_col));
  assign done     = active && (cur_col == CW'(COLS - 1));

  // Columns are visited in ascending order, so the first hit of a scan is
  // the minimum and every later hit pushes the maximum outward. The start
  // cycle discards whatever the previous scan left in any/min_col.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      col     <= '0;
      min_col <= '0;
      max_col <= '0;
      any     <= 1'b0;
    end else if (active) begin
      if (cur_hit) begin
        if (start || !any) begin
          min_col <= cur_col;
        end
        max_col <= cur_col;
      end
      any <= start ? cur_hit : (any | cur_hit);
      if (done) begin
        busy <= 1'b0;
        col  <= '0;
      end else begin
        busy <= 1'b1;
        col  <= cur_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/formation_ctrl.sv
// ---------------------------------------------------------------------------
// formation_ctrl
//   Enemy-formation controller: holds the alive mask of a ROWS x COLS grid
//   and the formation origin, marches the formation left/right, drops one
//   row at each screen edge (raising the speed level), and flags landing or
//   wipe-out. Enemy (r,c) sits at base_x + c*COL_PITCH, base_y + r*ROW_PITCH.
//
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     start       : one-cycle pulse, load a fresh formation (any state)
//     enable      : game running; low freezes the tick counter
//     kill_valid  : kill request for enemy kill_idx (row*COLS + col)
//     kill_idx    : enemy index; values >= ROWS*COLS are ignored
//     alive       : alive mask, bit row*COLS + col
//     base_x/y    : origin of enemy (0,0)
//     dir         : 0 = moving right, 1 = moving left
//     level       : descent count, saturating at 31
//     landed      : sticky, formation reached Y_LAND
//     cleared     : sticky, every enemy is dead
//     step_pulse  : one-cycle strobe after each completed step
//
//   Build option:
//     FORMATION_SPEEDUP_EN : when defined the horizontal step is
//                            STEP_X + level, otherwise STEP_X.
// ---------------------------------------------------------------------------
module formation_ctrl #(
  parameter int ROWS      = 5,
  parameter int COLS      = 11,
  parameter int PW        = 10,
  parameter int COL_PITCH = 30,
  parameter int ROW_PITCH = 30,
  parameter int X_MIN     = 150,
  parameter int X_MAX     = 760,
  parameter int Y_START   = 40,
  parameter int Y_LAND    = 400,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 16,
  parameter int TICK_DIV  = 2097152
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          enable,
  input  logic                          kill_valid,
  input  logic [$clog2(ROWS*COLS)-1:0]  kill_idx,
  output logic [ROWS*COLS-1:0]          alive,
  output logic [PW-1:0]                 base_x,
  output logic [PW-1:0]                 base_y,
  output logic                          dir,
  output logic [4:0]                    level,
  output logic                          landed,
  output logic                          cleared,
  output logic                          step_pulse
);
  import formation_pkg::*;

  localparam int CELLS = ROWS * COLS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Two guard bits so edge sums never wrap for on-screen positions.
  localparam int AW    = PW + 2;

  localparam logic [AW-1:0] COL_PITCH_A = AW'(COL_PITCH);
  localparam logic [AW-1:0] ROW_PITCH_A = AW'(ROW_PITCH);
  localparam logic [AW-1:0] X_MIN_A     = AW'(X_MIN);
  localparam logic [AW-1:0] X_MAX_A     = AW'(X_MAX);
  localparam logic [AW-1:0] Y_LAND_A    = AW'(Y_LAND);
  localparam logic [AW-1:0] STEP_X_A    = AW'(STEP_X);
  localparam logic [AW-1:0] STEP_Y_A    = AW'(STEP_Y);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);

  state_t            state;
  logic [TW-1:0]     tick;
  logic              pending_drop;
  logic [CELLS-1:0]  snap;
  logic              scan_first;
  logic              scan_start;
  logic [CW-1:0]     min_col;
  logic [CW-1:0]     max_col;
  logic              scan_any;
  logic              scan_done;
  logic [RW-1:0]     lo_row;
  logic [AW-1:0]     step_s;
  logic [AW-1:0]     right_reach;
  logic [AW-1:0]     left_reach;
  logic [AW-1:0]     new_y;
  logic [AW-1:0]     land_reach;
  logic              can_right;
  logic              can_left;
  logic              lands;
  logic              kill_ok;

  assign scan_start = (state == ST_SCAN) && scan_first;

  formation_scan #(
    .ROWS (ROWS),
    .COLS (COLS),
    .CW   (CW)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start    (scan_start),
    .snapshot (snap),
    .min_col  (min_col),
    .max_col  (max_col),
    .any      (scan_any),
    .done     (scan_done)
  );

  // The bottom-most row that still has a live enemy decides landing. It is
  // taken from the frozen snapshot so it agrees with the column extent.
  always_comb begin
    lo_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (|snap[r*COLS +: COLS]) begin
        lo_row = RW'(r);
      end
    end
  end

  // Edge and landing tests for the STEP cycle. The right test checks where
  // the rightmost live column would end up after the move; the left test is
  // written as "pos >= X_MIN + s" so it never needs a subtraction that could
  // underflow.
  always_comb begin
`ifdef FORMATION_SPEEDUP_EN
    step_s = STEP_X_A + AW'(level);
`else
    step_s = STEP_X_A;
`endif
    right_reach = AW'(base_x) + AW'(max_col) * COL_PITCH_A + step_s;
    left_reach  = AW'(base_x) + AW'(min_col) * COL_PITCH_A;
    new_y       = AW'(base_y) + STEP_Y_A;
    land_reach  = new_y + AW'(lo_row) * ROW_PITCH_A;
    can_right   = right_reach <= X_MAX_A;
    can_left    = left_reach >= (X_MIN_A + step_s);
    lands       = land_reach >= Y_LAND_A;
  end

  // Kills only count while a game is in progress; IDLE and HALT freeze the
  // mask so the final picture stays on screen.
  assign kill_ok = kill_valid && (32'(kill_idx) < CELLS) &&
                   ((state == ST_WAIT) || (state == ST_SCAN) || (state == ST_STEP));

  // Main controller. reset beats start, start beats everything else. In WAIT
  // the tick divider paces the march; SCAN freezes a snapshot of the mask
  // and lets the scanner walk the columns; STEP applies exactly one action:
  // declare the grid cleared, perform a pending drop, or move/turn.
  // A turn only flips dir and arms pending_drop so the drop happens on the
  // following step, which keeps the visible motion one action per tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      alive        <= '0;
      base_x       <= PW'(X_MIN);
      base_y       <= PW'(Y_START);
      dir          <= 1'b0;
      level        <= '0;
      landed       <= 1'b0;
      cleared      <= 1'b0;
      step_pulse   <= 1'b0;
      tick         <= '0;
      pending_drop <= 1'b0;
      snap         <= '0;
      scan_first   <= 1'b0;
    end else if (start) begin
      state        <= ST_WAIT;
      alive        <= '1;
      base_x       <= PW'(X_MIN);
      base_y       <= PW'(Y_START);
      dir          <= 1'b0;
      level        <= '0;
      landed       <= 1'b0;
      cleared      <= 1'b0;
      step_pulse   <= 1'b0;
      tick         <= '0;
      pending_drop <= 1'b0;
      snap         <= '0;
      scan_first   <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      scan_first <= 1'b0;
      if (kill_ok) begin
        alive[kill_idx] <= 1'b0;
      end
      case (state)
        ST_WAIT: begin
          if (enable) begin
            if (tick == TICK_LAST) begin
              tick       <= '0;
              snap       <= alive;
              scan_first <= 1'b1;
              state      <= ST_SCAN;
            end else begin
              tick <= tick + TW'(1);
            end
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            state <= ST_STEP;
          end
        end
        ST_STEP: begin
          if (!scan_any) begin
            cleared <= 1'b1;
            state   <= ST_HALT;
          end else if (pending_drop) begin
            base_y       <= new_y[PW-1:0];
            level        <= (level == 5'd31) ? level : level + 5'd1;
            pending_drop <= 1'b0;
            if (lands) begin
              landed <= 1'b1;
              state  <= ST_HALT;
            end else begin
              step_pulse <= 1'b1;
              state      <= ST_WAIT;
            end
          end else begin
            if (!dir) begin
              if (can_right) begin
                base_x <= base_x + step_s[PW-1:0];
              end else begin
                dir          <= 1'b1;
                pending_drop <= 1'b1;
              end
            end else begin
              if (can_left) begin
                base_x <= base_x - step_s[PW-1:0];
              end else begin
                dir          <= 1'b0;
                pending_drop <= 1'b1;
              end
            end
            step_pulse <= 1'b1;
            state      <= ST_WAIT;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_formation_ctrl.sv
// ---------------------------------------------------------------------------
// tb_formation_ctrl
//   Bench for formation_ctrl on a 2x3 grid with TICK_DIV=4. A behavioural
//   model queues the expected post-step outputs; a monitor pops one entry
//   per step_pulse. A second instance with a low landing line and a narrow
//   playfield covers landing.
// ---------------------------------------------------------------------------
module tb_formation_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       enable;
  logic       kill_valid;
  logic [2:0] kill_idx;
  logic [5:0] alive;
  logic [9:0] base_x;
  logic [9:0] base_y;
  logic       dir;
  logic [4:0] level;
  logic       landed;
  logic       cleared;
  logic       step_pulse;

  logic       l_start;
  logic       l_enable;
  logic       l_kill_valid;
  logic [2:0] l_kill_idx;
  logic [5:0] l_alive;
  logic [9:0] l_base_x;
  logic [9:0] l_base_y;
  logic       l_dir;
  logic [4:0] l_level;
  logic       l_landed;
  logic       l_cleared;
  logic       l_step_pulse;

  formation_ctrl #(.ROWS(2), .COLS(3), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable),
    .kill_valid(kill_valid), .kill_idx(kill_idx), .alive(alive),
    .base_x(base_x), .base_y(base_y), .dir(dir), .level(level),
    .landed(landed), .cleared(cleared), .step_pulse(step_pulse)
  );

  formation_ctrl #(.ROWS(2), .COLS(3), .TICK_DIV(4), .X_MAX(215), .Y_LAND(60)) dut_land (
    .clk(clk), .reset(reset), .start(l_start), .enable(l_enable),
    .kill_valid(l_kill_valid), .kill_idx(l_kill_idx), .alive(l_alive),
    .base_x(l_base_x), .base_y(l_base_y), .dir(l_dir), .level(l_level),
    .landed(l_landed), .cleared(l_cleared), .step_pulse(l_step_pulse)
  );

  // Free-running clock and an edge counter used for latency checks.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  int          pulse_cnt = 0;
  int          last_pulse_cyc = 0;

  int          m_x, m_y, m_dir, m_lvl, m_pend;
  logic [5:0]  m_alive;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] packExp();
    return {m_alive, 10'(m_x), 10'(m_y), 1'(m_dir), 5'(m_lvl)};
  endfunction

  task automatic modelReset();
    m_x = 150; m_y = 40; m_dir = 0; m_lvl = 0; m_pend = 0; m_alive = 6'h3F;
  endtask

  // One formation step computed directly from the rules; a step that
  // produces a step_pulse queues its expected outputs.
  task automatic modelStep(input logic [5:0] snap, output bit halted);
    bit any;
    int mn, mx, lo, s;
    any = 0; mn = 0; mx = 0;
    for (int c = 0; c < 3; c++) begin
      if (snap[c] || snap[3 + c]) begin
        if (!any) mn = c;
        mx  = c;
        any = 1;
      end
    end
    lo = (snap[5:3] != 3'b000) ? 1 : 0;
`ifdef FORMATION_SPEEDUP_EN
    s = 1 + m_lvl;
`else
    s = 1;
`endif
    halted = 0;
    if (!any) begin
      halted = 1;
    end else if (m_pend != 0) begin
      m_y   = m_y + 16;
      m_lvl = (m_lvl < 31) ? m_lvl + 1 : 31;
      m_pend = 0;
      if (m_y + lo * 30 >= 400) halted = 1;
    end else if (m_dir == 0) begin
      if (m_x + mx * 30 + s <= 760) m_x = m_x + s;
      else begin m_dir = 1; m_pend = 1; end
    end else begin
      if (m_x + mn * 30 >= 150 + s) m_x = m_x - s;
      else begin m_dir = 0; m_pend = 1; end
    end
    if (!halted) exp_q.push_back(packExp());
  endtask

  // Scoreboard consumer: each step_pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (!reset && step_pulse) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      if (exp_q.size() == 0)
        checkOutput("unexpected_step", 32'(exp_q.size()), 32'd1);
      else
        checkOutput("step", {alive, base_x, base_y, dir, level}, exp_q.pop_front());
    end
  end

  task automatic tick1();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic kv, input logic [2:0] ki);
    start = st; kill_valid = kv; kill_idx = ki;
    tick1();
    start = 1'b0; kill_valid = 1'b0;
  endtask

  task automatic applyLandStimulus(input logic st, input logic kv, input logic [2:0] ki);
    l_start = st; l_kill_valid = kv; l_kill_idx = ki;
    tick1();
    l_start = 1'b0; l_kill_valid = 1'b0;
  endtask

  task automatic waitPulses(input int n);
    int target, budget;
    target = pulse_cnt + n;
    budget = n * 8 + 40;
    while (pulse_cnt < target && budget > 0) begin
      tick1();
      budget--;
    end
    if (pulse_cnt < target) checkOutput("pulse_timeout", 32'(pulse_cnt), 32'(target));
  endtask

  task automatic runSteps(input int n);
    bit h;
    for (int i = 0; i < n; i++) modelStep(m_alive, h);
    waitPulses(n);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  start_cyc, prev, budget, saved;
    bit  h;
    reset = 1'b1; start = 1'b0; enable = 1'b1; kill_valid = 1'b0; kill_idx = '0;
    l_start = 1'b0; l_enable = 1'b1; l_kill_valid = 1'b0; l_kill_idx = '0;
    repeat (3) tick1();

    // reset must win over start
    start = 1'b1; tick1(); start = 1'b0;
    checkOutput("reset_alive", 32'(alive), 32'd0);
    checkOutput("reset_pos", {base_x, base_y}, {10'd150, 10'd40});
    checkOutput("reset_flags", {dir, level, landed, cleared, step_pulse}, 32'd0);
    reset = 1'b0;
    tick1();

    // kill in IDLE is ignored
    applyStimulus(1'b0, 1'b1, 3'd0);
    checkOutput("idle_kill", 32'(alive), 32'd0);

    // fresh formation and first-step latency
    modelReset();
    applyStimulus(1'b1, 1'b0, 3'd0);
    start_cyc = cyc;
    checkOutput("start_state", {alive, base_x, base_y, dir, level}, packExp());
    modelStep(m_alive, h);
    waitPulses(1);
    checkOutput("first_pulse_lat", 32'(last_pulse_cyc - start_cyc), 32'd8);

    // march to the right edge, turn, then drop
    runSteps(549);
    checkOutput("right_edge_x", 32'(base_x), 32'd700);
    runSteps(1);
    checkOutput("turn", {dir, base_x}, {1'b1, 10'd700});
    runSteps(1);
    checkOutput("drop", {base_y, level}, {10'd56, 5'd1});
    runSteps(1);
    checkOutput("left_x", 32'(base_x), 32'd699);

    // enable low for 10 cycles in WAIT stretches the step period by 10
    prev = last_pulse_cyc;
    tick1();
    enable = 1'b0;
    repeat (10) tick1();
    enable = 1'b1;
    modelStep(m_alive, h);
    waitPulses(1);
    checkOutput("pause_period", 32'(last_pulse_cyc - prev), 32'd18);

    // start during SCAN reloads the formation
    repeat (5) tick1();
    modelReset();
    applyStimulus(1'b1, 1'b0, 3'd0);
    start_cyc = cyc;
    checkOutput("midscan_reload", {alive, base_x, base_y, dir, level}, packExp());
    checkOutput("midscan_flags", {landed, cleared}, 32'd0);
    modelStep(m_alive, h);
    waitPulses(1);
    checkOutput("reload_lat", 32'(last_pulse_cyc - start_cyc), 32'd8);

    // kill column 2, plus an out-of-range index that must be ignored
    applyStimulus(1'b0, 1'b1, 3'd2);
    applyStimulus(1'b0, 1'b1, 3'd5);
    applyStimulus(1'b0, 1'b1, 3'd7);
    m_alive = 6'b011011;
    runSteps(579);
    checkOutput("narrow_edge_x", 32'(base_x), 32'd730);
    runSteps(1);
    checkOutput("narrow_turn", {dir, base_x}, {1'b1, 10'd730});

    // wipe out the grid; the pending drop still completes, then cleared
    m_alive = 6'b000000;
    modelStep(6'b011011, h);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 3'(i));
    waitPulses(1);
    budget = 30;
    while (!cleared && budget > 0) begin tick1(); budget--; end
    checkOutput("cleared", 32'(cleared), 32'd1);
    checkOutput("clear_lat", 32'(cyc - last_pulse_cyc), 32'd8);
    saved = pulse_cnt;
    repeat (24) tick1();
    checkOutput("halt_pos", {base_x, base_y}, {10'(m_x), 10'(m_y)});
    checkOutput("halt_pulses", 32'(pulse_cnt), 32'(saved));

    // landing instance: first descent lands
    applyLandStimulus(1'b1, 1'b0, 3'd0);
    start_cyc = cyc;
    budget = 200;
    while (!l_landed && budget > 0) begin tick1(); budget--; end
    checkOutput("land_flag", 32'(l_landed), 32'd1);
    checkOutput("land_lat", 32'(cyc - start_cyc), 32'd56);
    checkOutput("land_no_pulse", 32'(l_step_pulse), 32'd0);
    checkOutput("land_pos", {l_base_x, l_base_y, l_level}, {10'd155, 10'd56, 5'd1});
    applyLandStimulus(1'b0, 1'b1, 3'd0);
    checkOutput("halt_kill", 32'(l_alive), 32'h3F);

    // bottom row gone: the same descent does not land
    applyLandStimulus(1'b1, 1'b0, 3'd0);
    start_cyc = cyc;
    applyLandStimulus(1'b0, 1'b1, 3'd3);
    applyLandStimulus(1'b0, 1'b1, 3'd4);
    applyLandStimulus(1'b0, 1'b1, 3'd5);
    while (cyc < start_cyc + 100) tick1();
    checkOutput("noland_flags", {l_landed, l_cleared, l_dir}, 32'b001);
    checkOutput("noland_pos", {l_alive, l_base_x, l_base_y, l_level},
                {6'b000111, 10'd150, 10'd56, 5'd1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/formation_ctrl.md
# formation_ctrl

Parametrised enemy-formation controller for the Space Invaders datapath. It holds the alive mask of a ROWS×COLS enemy grid and the formation origin, and steps the formation left and right. It drops one row at each screen edge and raises its speed level on every drop. It flags when the grid is wiped out or when it has landed. It sits between the game FSM (start/enable), the collision logic (kill requests) and the enemy sprite renderers, which derive each enemy position from the origin.

## Interface
Parameters:
- ROWS, 5: grid rows.
- COLS, 11: grid columns.
- PW, 10: position width in bits.
- COL_PITCH, 30: horizontal distance between columns, in pixels.
- ROW_PITCH, 30: vertical distance between rows, in pixels.
- X_MIN, 150: left bound for the leftmost alive enemy.
- X_MAX, 760: right bound for the rightmost alive enemy.
- Y_START, 40: initial base_y.
- Y_LAND, 400: landing line.
- STEP_X, 1: base horizontal step, in pixels.
- STEP_Y, 16: descent per edge hit, in pixels.
- TICK_DIV, 2097152: clk cycles spent in WAIT per step (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset (synchronous, active-high).
- start  in  1  one-cycle pulse: load a fresh formation.
- enable  in  1  game running; low pauses the tick counter.
- kill_valid  in  1  kill request.
- kill_idx  in  $clog2(ROWS*COLS)  enemy index, computed as row*COLS+col.
- alive  out  ROWS*COLS  alive mask.
- base_x, base_y  out  PW  origin of enemy (0,0). Enemy (r,c) is at base_x+c·COL_PITCH, base_y+r·ROW_PITCH.
- dir  out  1  0 = right, 1 = left.
- level  out  5  descent count, saturating at 31.
- landed  out  1  sticky: formation reached Y_LAND.
- cleared  out  1  sticky: all enemies dead.
- step_pulse  out  1  one-cycle strobe after each completed step.

## Operation
States:
- IDLE: waits for start.
- WAIT: tick counter runs.
- SCAN: finds the alive column extent.
- STEP: applies the move.
- HALT: terminal state until start.

Reset and start:
- Reset puts the block in IDLE with alive=0, base_x=X_MIN, base_y=Y_START, dir=0, level=0, landed=0, cleared=0, step_pulse=0, tick counter 0, pending_drop=0.
- start, in any state, sets alive to all-ones, restores every other register to its reset value and enters WAIT.
- reset has priority over start. start has priority over kill.

WAIT:
- The counter increments only while enable=1.
- When the counter reaches TICK_DIV-1 it clears and the block enters SCAN.

SCAN:
- On entry the block latches a snapshot of alive.
- It visits one column per cycle, COLS cycles in total, recording min_col and max_col among columns that have any alive enemy.
- lo_row, the highest-indexed row with any alive enemy, is computed combinationally from the snapshot.

STEP (1 cycle):
- Empty snapshot: cleared←1, go to HALT.
- pending_drop=1: base_y+=STEP_Y, level++ (saturating), pending_drop←0. Then, if base_y_new+lo_row·ROW_PITCH ≥ Y_LAND, set landed←1 and go to HALT.
- Otherwise, with s = step size (see Configuration):
  - dir=0: if base_x+max_col·COL_PITCH+s ≤ X_MAX then base_x+=s; else dir←1 and pending_drop←1 (no x move).
  - dir=1: if base_x+min_col·COL_PITCH ≥ X_MIN+s then base_x−=s; else dir←0 and pending_drop←1.
- Unless the block went to HALT, it returns to WAIT.

Kill requests:
- In WAIT, SCAN or STEP, kill_valid clears alive[kill_idx] on the next edge.
- kill_idx ≥ ROWS*COLS is ignored. Killing a dead enemy has no effect.
- Kills are ignored in IDLE and HALT.
- A kill during SCAN does not affect the current step; it is seen on the next scan.

Arithmetic: comparisons use PW+2 bits unsigned, with no wrap.

## Timing
- Step period is TICK_DIV+COLS+1 cycles at constant enable=1.
- Outputs update at the clock edge ending STEP. step_pulse is high the following cycle, also when the step flipped dir without moving.
- When enable drops, the counter freezes immediately. SCAN and STEP still complete if already entered.
- landed and cleared rise on the same edge as the STEP update. step_pulse is not asserted on the transition to HALT.

## Configuration
- FORMATION_SPEEDUP_EN defined: s = STEP_X+level.
- FORMATION_SPEEDUP_EN undefined: s = STEP_X. level still counts descents.

## Structure
- Package formation_pkg holds the state enum, the index-width constant, and a function computing one column's alive-OR from a mask.
- Sub-module formation_scan is the sequential column scanner. Interface: start, snapshot in; min_col, max_col, any, done out.

## Test plan
Use ROWS=2, COLS=3, TICK_DIV=4 and default pitches/bounds unless noted.
1. Reset, then start → alive=6'b111111, base_x=150, base_y=40. First step_pulse 8 cycles after start, with base_x=151.
2. Run until the right edge (max_col=2: 150+60 → 700 limit) → base_x stops at 700. Next step sets dir=1 with no move. The following step gives base_y=56, level=1.
3. Kill column 2 (idx 2 and 5) before the edge → the formation travels to base_x=730 before turning.
4. Kill all 6 one per cycle → cleared=1 and HALT at the next STEP. Further ticks keep base_x unchanged.
5. Y_LAND=60 → the first descent gives base_y=56, 56+30 ≥ 60 → landed=1. With bottom row killed, lo_row=0 → no landing.
6. enable=0 mid-WAIT for 10 cycles → step period extends by exactly 10. start mid-SCAN → full formation reload, state WAIT.
